hex_step_counter: RTL

//  Button-stepped up/down counter, generalised to CNT_W bits.

---
 rtl/hex_step_counter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hex_step_counter.sv
// Button-stepped up/down counter with switch load, wrap/saturate limits and a hex readout.
// Optional key debounce is enabled by defining KEY_DEBOUNCE_EN.
module hex_step_counter #(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned SW_W            = 10,
    parameter bit          SATURATE        = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                        clk100_i,
    input  logic                        rst_i,
    input  logic [SW_W-1:0]             sw_i,
    input  logic [1:0]                  key_i,
    input  logic                        dir_i,
    output logic [SW_W-1:0]             ledr_o,
    output logic [CNT_W-1:0]            cnt_o,
    output logic                        wrap_o,
    output logic [7*(CNT_W/4)-1:0]      hex_o
);

    localparam int unsigned NUM_DIGITS = CNT_W / 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((CNT_W % 4) != 0 || CNT_W == 0 || DEBOUNCE_CYCLES == 0) begin : g_param_check
        $error("hex_step_counter: CNT_W must be a non-zero multiple of 4 and DEBOUNCE_CYCLES non-zero");
    end

    logic [1:0] w_press;

    // Per key: 3-FF synchroniser on the inverted (active-high) key, then edge or debounced edge.
    for (genvar n = 0; n < 2; n++) begin : g_key
        logic [2:0] r_sync;

        always_ff @(posedge clk100_i) begin
            if (rst_i) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[1:0], ~key_i[n]};
            end
        end

`ifdef KEY_DEBOUNCE_EN
        localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
        localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

        logic            r_acc;
        logic [DB_W-1:0] r_db_cnt;
        logic            w_differ;

        assign w_differ = r_sync[2] ^ r_acc;

        // Accepted level follows the synchronised level only after a full run of disagreement.
        always_ff @(posedge clk100_i) begin
            if (rst_i) begin
                r_acc    <= 1'b0;
                r_db_cnt <= '0;
            end else if (!w_differ) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_acc    <= r_sync[2];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end

        assign w_press[n] = w_differ && (r_db_cnt == DB_LAST) && r_sync[2];
`else
        assign w_press[n] = r_sync[1] & ~r_sync[2];
`endif
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SW_W-1:0]  r_ledr;
    logic [SW_W-1:0]  w_ledr_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;

    // Load has priority over step; limit events either wrap or hold.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_ledr_nxt = r_ledr;
        w_wrap_nxt = 1'b0;
        if (w_press[1]) begin
            w_cnt_nxt  = CNT_W'(sw_i);
            w_ledr_nxt = sw_i;
        end else if (w_press[0]) begin
            if (dir_i) begin
                if (r_cnt == CNT_MAX) begin
                    w_wrap_nxt = 1'b1;
                    w_cnt_nxt  = SATURATE ? CNT_MAX : '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else begin
                if (r_cnt == '0) begin
                    w_wrap_nxt = 1'b1;
                    w_cnt_nxt  = SATURATE ? '0 : CNT_MAX;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_ledr <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ledr <= w_ledr_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign cnt_o  = r_cnt;
    assign ledr_o = r_ledr;
    assign wrap_o = r_wrap;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        seg7 = 7'h7F;
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign hex_o[7*k +: 7] = seg7(r_cnt[4*k +: 4]);
    end

endmodule
